// File: rtl/img2col_pkg.sv
// Shared types and helpers for the img2col window processing unit.
package img2col_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } pu_state_t;

  localparam int DEF_K      = 5;
  localparam int DEF_DATA_W = 16;

  // Column of the default geometry; parametrised instances size their own buses.
  typedef logic [DEF_K*DEF_DATA_W-1:0] col_t;

  // A zero stride would never advance the window; beyond K columns would be skipped.
  function automatic int clamp_stride(input int stride, input int k);
    if (stride == 0) return 1;
    if (stride > k) return k;
    return stride;
  endfunction

endpackage

// File: rtl/img2col_col_shifter.sv
// K-column window shift register: new columns enter at c=K-1, the column
// leaving c=0 is offered on a registered retire port when enabled.
module img2col_col_shifter
  import img2col_pkg::*;
#(
  parameter int K      = 5,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    pad,
  input  logic                    retire_en,
  input  logic [K*DATA_W-1:0]     col_in,
  output logic [K*K*DATA_W-1:0]   win,
  output logic                    retire_valid,
  output logic [K*DATA_W-1:0]     retire_data
);

  localparam int CW = K * DATA_W;

  logic [CW-1:0] cols_reg [K];
  logic [CW-1:0] tail_next;

  assign tail_next = pad ? '0 : col_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < K; c++) cols_reg[c] <= '0;
    end else if (load) begin
      for (int c = 0; c < K - 1; c++) cols_reg[c] <= cols_reg[c+1];
      cols_reg[K-1] <= tail_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_win
      assign win[gi*CW +: CW] = cols_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_valid <= 1'b0;
      retire_data  <= '0;
    end else begin
      retire_valid <= load & retire_en;
      if (load && retire_en) retire_data <= cols_reg[0];
    end
  end

endmodule

// File: rtl/img2col_window_pu.sv
// img2col processing unit: gathers K-pixel columns into a KxK window and emits
// one flattened window per handshake, stepping by a runtime stride.
module img2col_window_pu
  import img2col_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(K+1)-1:0]    cfg_stride,
  input  logic [CNT_W-1:0]          cfg_windows,
  input  logic                      cfg_src,
  input  logic                      axi_col_valid,
  input  logic [K*DATA_W-1:0]       axi_col_data,
  input  logic                      nb_in_valid,
  input  logic [K*DATA_W-1:0]       nb_in_data,
  input  logic                      in_pad,
  output logic                      col_ready,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [K*K*DATA_W-1:0]     win_data,
  output logic                      nb_out_valid,
  output logic [K*DATA_W-1:0]       nb_out_data,
  output logic                      busy,
  output logic                      row_done
);

  localparam int SW = $clog2(K + 1);

  pu_state_t         state_reg, state_next;
  logic [SW-1:0]     stride_reg, col_cnt_reg, need_cnt;
  logic [CNT_W-1:0]  windows_reg, win_cnt_reg;
  logic              src_reg, filled_reg;
  logic              sel_valid, accept, last_col, handshake, last_win;
  logic [K*DATA_W-1:0] sel_data;

  assign sel_valid = src_reg ? nb_in_valid : axi_col_valid;
  assign sel_data  = src_reg ? nb_in_data  : axi_col_data;

  assign col_ready = (state_reg == FILL);
  assign win_valid = (state_reg == EMIT);
  assign busy      = (state_reg != IDLE);
  assign row_done  = (state_reg == DONE);

  assign accept    = col_ready & sel_valid;
  // The first window needs a full K columns; later ones only the stride.
  assign need_cnt  = filled_reg ? stride_reg : SW'(K);
  assign last_col  = accept && ((col_cnt_reg + SW'(1)) == need_cnt);
  assign handshake = win_valid & win_ready;
  assign last_win  = (win_cnt_reg + CNT_W'(1)) == windows_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (cfg_windows == '0) ? DONE : FILL;
      FILL:    if (last_col) state_next = EMIT;
      EMIT:    if (handshake) state_next = last_win ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      stride_reg  <= '0;
      windows_reg <= '0;
      win_cnt_reg <= '0;
      col_cnt_reg <= '0;
      src_reg     <= 1'b0;
      filled_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        stride_reg  <= SW'(clamp_stride(int'(cfg_stride), K));
        windows_reg <= cfg_windows;
        src_reg     <= cfg_src;
        win_cnt_reg <= '0;
        col_cnt_reg <= '0;
        filled_reg  <= 1'b0;
      end
      if (accept) col_cnt_reg <= last_col ? '0 : col_cnt_reg + SW'(1);
      if (last_col) filled_reg <= 1'b1;
      if (handshake) win_cnt_reg <= win_cnt_reg + CNT_W'(1);
    end
  end

  // Shift-outs during the initial fill are stale data and stay internal.
  img2col_col_shifter #(
    .K      (K),
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .pad          (in_pad),
    .retire_en    (filled_reg),
    .col_in       (sel_data),
    .win          (win_data),
    .retire_valid (nb_out_valid),
    .retire_data  (nb_out_data)
  );

endmodule

// File: tb/tb_img2col_window_pu.sv
// Directed bench for img2col_window_pu (K=3, DATA_W=8) with a column-list
// reference model checked every cycle, plus literal window/retire expectations.
module tb_img2col_window_pu;

  localparam int K = 3, DATA_W = 8, CNT_W = 16;
  localparam int SW = $clog2(K + 1), CW = K * DATA_W, WW = K * K * DATA_W;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [SW-1:0]    cfg_stride = '0;
  logic [CNT_W-1:0] cfg_windows = '0;
  logic cfg_src = 1'b0, axi_col_valid = 1'b0, nb_in_valid = 1'b0, in_pad = 1'b0, win_ready = 1'b0;
  logic [CW-1:0] axi_col_data = '0, nb_in_data = '0;
  logic col_ready, win_valid, nb_out_valid, busy, row_done;
  logic [WW-1:0] win_data;
  logic [CW-1:0] nb_out_data;

  always #5 clk = ~clk;

  img2col_window_pu #(.DATA_W(DATA_W), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride), .cfg_windows(cfg_windows),
    .cfg_src(cfg_src), .axi_col_valid(axi_col_valid), .axi_col_data(axi_col_data),
    .nb_in_valid(nb_in_valid), .nb_in_data(nb_in_data), .in_pad(in_pad),
    .col_ready(col_ready), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .nb_out_valid(nb_out_valid), .nb_out_data(nb_out_data), .busy(busy), .row_done(row_done)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] col(input int c);
    logic [CW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DATA_W +: DATA_W] = DATA_W'(10 * c + r);
    return v;
  endfunction

  // Reference model: list of accepted columns; window n = columns n*stride .. n*stride+K-1.
  logic [CW-1:0] acc [64];
  int acc_n = 0, win_idx = 0, m_stride = 1;
  logic m_src = 1'b0, exp_nbv = 1'b0;
  logic [CW-1:0] exp_nbd = '0;
  logic [CW-1:0] nb_log [16];
  int nb_cyc [16];
  int nb_n = 0;
  logic [WW-1:0] got_win [8];
  int got_n = 0;

  function automatic logic [WW-1:0] model_win(input int base);
    logic [WW-1:0] v;
    for (int c = 0; c < K; c++) v[c*CW +: CW] = acc[base + c];
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_nbv = 1'b0;
    end else begin
      chk("nb_out_valid", 128'(nb_out_valid), 128'(exp_nbv));
      if (exp_nbv) chk("nb_out_data", 128'(nb_out_data), 128'(exp_nbd));
      if (nb_out_valid && nb_n < 16) begin
        nb_log[nb_n] = nb_out_data;
        nb_cyc[nb_n] = cyc;
        nb_n++;
      end
      if (win_valid) begin
        chk("win_no_col_ready", 128'(col_ready), 128'(0));
        if (win_idx * m_stride + K > acc_n) chk("win_early", 128'(acc_n), 128'(win_idx * m_stride + K));
        else chk("win_data_model", 128'(win_data), 128'(model_win(win_idx * m_stride)));
        if (win_ready) win_idx++;
      end
      exp_nbv = 1'b0;
      if (col_ready && (m_src ? nb_in_valid : axi_col_valid)) begin
        if (acc_n >= K) begin
          exp_nbv = 1'b1;
          exp_nbd = acc[acc_n - K];
        end
        if (acc_n < 64) begin
          acc[acc_n] = in_pad ? '0 : (m_src ? nb_in_data : axi_col_data);
          acc_n++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int stride, input int n, input bit src, input int exp_stride);
    cfg_stride = SW'(stride);
    cfg_windows = CNT_W'(n);
    cfg_src = src;
    start = 1'b1;
    acc_n = 0; win_idx = 0; m_stride = exp_stride; m_src = src; nb_n = 0; got_n = 0;
    tick();
    start = 1'b0;
    // scramble cfg: the row must run on the values latched at start
    cfg_stride = '0; cfg_windows = CNT_W'(5); cfg_src = ~src;
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("col_ready_after_start", 128'(col_ready), 128'(n != 0));
  endtask

  task automatic feed_col(input int c, input bit pad);
    int w = 0;
    in_pad = pad;
    if (m_src) begin
      nb_in_data = col(c); nb_in_valid = 1'b1;
      axi_col_data = {CW{1'b1}}; axi_col_valid = 1'b1;
    end else begin
      axi_col_data = col(c); axi_col_valid = 1'b1;
    end
    while (!col_ready && w < 20) begin tick(); w++; end
    if (w >= 20) chk("col_ready_timeout", 128'(col_ready), 128'(1));
    tick();
    nb_in_valid = 1'b0; axi_col_valid = 1'b0; in_pad = 1'b0;
  endtask

  task automatic take_win(input int hold);
    logic [WW-1:0] snap;
    int w = 0;
    chk("win_valid_latency", 128'(win_valid), 128'(1));
    while (!win_valid && w < 20) begin tick(); w++; end
    snap = win_data;
    for (int i = 0; i < hold; i++) begin
      win_ready = 1'b0;
      tick();
      chk("bp_win_valid", 128'(win_valid), 128'(1));
      chk("bp_col_ready", 128'(col_ready), 128'(0));
      chk("bp_win_data_hold", 128'(win_data), 128'(snap));
    end
    if (got_n < 8) begin
      got_win[got_n] = win_data;
      got_n++;
    end
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
  endtask

  task automatic run_row(input int stride, input int exp_stride, input int n, input bit src,
                         input bit pad_first, input int hold_first, input bit poke);
    int c = 0;
    do_start(stride, n, src, exp_stride);
    if (src) begin
      // stray AXI traffic while the neighbour source is selected
      axi_col_data = col(9); axi_col_valid = 1'b1;
      tick(); tick();
      axi_col_valid = 1'b0;
    end
    for (int w = 0; w < n; w++) begin
      int need = (w == 0) ? K : exp_stride;
      for (int i = 0; i < need; i++) begin
        if (poke && c == 1) begin
          start = 1'b1; cfg_windows = '0; cfg_stride = SW'(2);
        end
        feed_col(c, pad_first && c == 0);
        start = 1'b0;
        c++;
      end
      take_win(w == 0 ? hold_first : 0);
      if (w < n - 1) begin
        chk("fill_resume", 128'(col_ready), 128'(1));
        chk("win_valid_drop", 128'(win_valid), 128'(0));
      end
    end
    chk("row_done_pulse", 128'(row_done), 128'(1));
    chk("no_col_ready_in_done", 128'(col_ready), 128'(0));
    tick();
    chk("row_done_end", 128'(row_done), 128'(0));
    chk("busy_end", 128'(busy), 128'(0));
  endtask

  localparam logic [WW-1:0] W012 = 72'h161514_0C0B0A_020100;
  localparam logic [WW-1:0] W123 = 72'h201F1E_161514_0C0B0A;
  localparam logic [WW-1:0] W234 = 72'h2A2928_201F1E_161514;
  localparam logic [WW-1:0] W345 = 72'h343332_2A2928_201F1E;
  localparam logic [WW-1:0] WPAD = 72'h161514_0C0B0A_000000;
  localparam logic [CW-1:0] C0 = 24'h020100, C1 = 24'h0C0B0A;

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_col_ready"}, 128'(col_ready), 128'(0));
    chk({tag, "_win_valid"}, 128'(win_valid), 128'(0));
    chk({tag, "_nb_out_valid"}, 128'(nb_out_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_row_done"}, 128'(row_done), 128'(0));
    chk({tag, "_win_data"}, 128'(win_data), 128'(0));
    chk({tag, "_nb_out_data"}, 128'(nb_out_data), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    run_row(1, 1, 3, 1'b0, 1'b0, 0, 1'b0);
    $display("row stride=1 windows=3: %0d windows, %0d retired", got_n, nb_n);
    chk("s1_win0", 128'(got_win[0]), 128'(W012));
    chk("s1_win1", 128'(got_win[1]), 128'(W123));
    chk("s1_win2", 128'(got_win[2]), 128'(W234));
    chk("s1_nb_count", 128'(nb_n), 128'(2));
    chk("s1_nb0", 128'(nb_log[0]), 128'(C0));
    chk("s1_nb1", 128'(nb_log[1]), 128'(C1));

    run_row(2, 2, 2, 1'b0, 1'b0, 0, 1'b0);
    $display("row stride=2 windows=2: %0d windows, %0d retired", got_n, nb_n);
    chk("s2_win1", 128'(got_win[1]), 128'(W234));
    chk("s2_nb0", 128'(nb_log[0]), 128'(C0));
    chk("s2_nb1", 128'(nb_log[1]), 128'(C1));
    chk("s2_nb_consecutive", 128'(nb_cyc[1] - nb_cyc[0]), 128'(1));

    run_row(1, 1, 2, 1'b0, 1'b0, 4, 1'b0);
    $display("row backpressure hold=4: %0d windows", got_n);
    chk("bp_win0", 128'(got_win[0]), 128'(W012));
    chk("bp_win1", 128'(got_win[1]), 128'(W123));

    run_row(1, 1, 1, 1'b0, 1'b1, 0, 1'b0);
    $display("row pad on column 0: %0d windows", got_n);
    chk("pad_win0", 128'(got_win[0]), 128'(WPAD));

    run_row(1, 1, 2, 1'b1, 1'b0, 0, 1'b0);
    $display("row neighbour source: %0d windows", got_n);
    chk("nb_src_win1", 128'(got_win[1]), 128'(W123));

    do_start(1, 0, 1'b0, 1);
    $display("row windows=0");
    chk("zero_win_row_done", 128'(row_done), 128'(1));
    tick();
    chk("zero_win_row_done_end", 128'(row_done), 128'(0));
    chk("zero_win_busy_end", 128'(busy), 128'(0));

    run_row(0, 1, 2, 1'b0, 1'b0, 0, 1'b0);
    $display("row stride=0: %0d windows", got_n);
    chk("stride0_win1", 128'(got_win[1]), 128'(W123));

    run_row(7, 3, 2, 1'b0, 1'b0, 0, 1'b0);
    $display("row stride=7: %0d windows", got_n);
    chk("stride7_win1", 128'(got_win[1]), 128'(W345));

    run_row(1, 1, 2, 1'b0, 1'b0, 0, 1'b1);
    $display("row start while busy: %0d windows", got_n);
    chk("poke_win1", 128'(got_win[1]), 128'(W123));

    do_start(1, 2, 1'b0, 1);
    feed_col(0, 1'b0);
    feed_col(1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-fill");
    chk_zero_outputs("midrst");
    tick();
    run_row(1, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    $display("row after reset: %0d windows", got_n);
    chk("refill_win0", 128'(got_win[0]), 128'(W012));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
